// File: rtl/i2c_master_seq.sv
// Byte-level I2C master sequencer: runs one START/STOP/WRITE/READ command at a time,
// generating push-pull SCL and open-drain SDA, and returns one response per command.
module i2c_master_seq #(
  parameter int unsigned QDIV   = 50,
  parameter int unsigned QDIV_W = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_wdata,
  input  logic       cmd_nack,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_ack,
  output logic       rsp_err,
  output logic       busy,
  output logic       bus_held,
  output logic       io_scl,
  input  logic       io_sda_in,
  output logic       io_sda_out,
  output logic       io_sda_ctrl
);

  localparam logic [1:0] OpStart = 2'b00;
  localparam logic [1:0] OpStop  = 2'b01;
  localparam logic [1:0] OpWrite = 2'b10;
  localparam logic [1:0] OpRead  = 2'b11;
  localparam logic [QDIV_W-1:0] QLast = QDIV_W'(QDIV - 1);

  typedef enum logic [2:0] {StIdle, StHeld, StStart, StStop, StXfer} state_e;

  state_e            state_q;
  logic [QDIV_W-1:0] qcnt_q;
  logic [1:0]        phase_q;
  logic [3:0]        bit_q;
  logic              rd_q, nack_q, ack_smp_q;
  logic [7:0]        shift_q;
  logic              scl_q, sda_ctrl_q, busy_q, held_q;
  logic              rsp_valid_q, ack_q, err_q;
  logic [7:0]        rdata_q;
  logic              q_last;

  assign q_last = (qcnt_q == QLast);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      qcnt_q      <= '0;
      phase_q     <= '0;
      bit_q       <= '0;
      rd_q        <= 1'b0;
      nack_q      <= 1'b0;
      ack_smp_q   <= 1'b0;
      shift_q     <= '0;
      scl_q       <= 1'b1;
      sda_ctrl_q  <= 1'b0;
      busy_q      <= 1'b0;
      held_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      if (busy_q) begin
        qcnt_q <= q_last ? '0 : qcnt_q + QDIV_W'(1);
        if (q_last) phase_q <= phase_q + 2'd1;
      end
      unique case (state_q)
        StIdle, StHeld: begin
          if (cmd_valid) begin
            qcnt_q  <= '0;
            phase_q <= '0;
            bit_q   <= '0;
            unique case (cmd_op)
              OpStart: begin
                state_q    <= StStart;
                busy_q     <= 1'b1;
                sda_ctrl_q <= 1'b0;
              end
              OpStop: begin
                if (state_q == StHeld) begin
                  state_q    <= StStop;
                  busy_q     <= 1'b1;
                  sda_ctrl_q <= 1'b1;
                end else begin
                  rsp_valid_q <= 1'b1;
                  ack_q       <= 1'b0;
                  err_q       <= 1'b1;
                end
              end
              OpWrite, OpRead: begin
                if (state_q == StHeld) begin
                  state_q    <= StXfer;
                  busy_q     <= 1'b1;
                  rd_q       <= cmd_op[0];
                  nack_q     <= cmd_nack;
                  shift_q    <= cmd_wdata;
                  scl_q      <= 1'b0;
                  sda_ctrl_q <= cmd_op[0] ? 1'b0 : ~cmd_wdata[7];
                end else begin
                  rsp_valid_q <= 1'b1;
                  ack_q       <= 1'b0;
                  err_q       <= 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
        StStart: begin
          if (q_last) begin
            unique case (phase_q)
              2'd0: scl_q <= 1'b1;
              2'd1: sda_ctrl_q <= 1'b1;
              2'd2: scl_q <= 1'b0;
              default: begin
                state_q     <= StHeld;
                held_q      <= 1'b1;
                busy_q      <= 1'b0;
                sda_ctrl_q  <= 1'b0;
                rsp_valid_q <= 1'b1;
                ack_q       <= 1'b0;
                err_q       <= 1'b0;
              end
            endcase
          end
        end
        StStop: begin
          if (q_last) begin
            unique case (phase_q)
              2'd0: scl_q <= 1'b1;
              2'd1: sda_ctrl_q <= 1'b0;
              2'd2: ;
              default: begin
                state_q     <= StIdle;
                held_q      <= 1'b0;
                busy_q      <= 1'b0;
                rsp_valid_q <= 1'b1;
                ack_q       <= 1'b0;
                err_q       <= 1'b0;
              end
            endcase
          end
        end
        StXfer: begin
          // Sample on the last clk of q1, i.e. in the middle of SCL high.
          if (phase_q == 2'd1 && q_last) begin
            if (bit_q == 4'd8) ack_smp_q <= ~io_sda_in;
            else if (rd_q) shift_q <= {shift_q[6:0], io_sda_in};
          end
          if (q_last) begin
            unique case (phase_q)
              2'd0: scl_q <= 1'b1;
              2'd1: ;
              2'd2: scl_q <= 1'b0;
              default: begin
                if (bit_q == 4'd8) begin
                  state_q     <= StHeld;
                  busy_q      <= 1'b0;
                  sda_ctrl_q  <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  ack_q       <= ~rd_q & ack_smp_q;
                  err_q       <= 1'b0;
                  if (rd_q) rdata_q <= shift_q;
                end else begin
                  bit_q <= bit_q + 4'd1;
                  if (rd_q) begin
                    sda_ctrl_q <= (bit_q == 4'd7) & ~nack_q;
                  end else begin
                    shift_q    <= {shift_q[6:0], 1'b0};
                    sda_ctrl_q <= (bit_q == 4'd7) ? 1'b0 : ~shift_q[6];
                  end
                end
              end
            endcase
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cmd_ready   = (state_q == StIdle) || (state_q == StHeld);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rdata_q;
  assign rsp_ack     = ack_q;
  assign rsp_err     = err_q;
  assign busy        = busy_q;
  assign bus_held    = held_q;
  assign io_scl      = scl_q;
  assign io_sda_out  = 1'b0;
  assign io_sda_ctrl = sda_ctrl_q;

endmodule

// File: tb/tb_i2c_master_seq.sv
// Bench for i2c_master_seq: a behavioural I2C slave and bus monitor decode the pad lines
// and expected results are computed from the protocol rules.
module tb_i2c_master_seq;
  localparam int unsigned QDIV = 4;
  localparam int XLAT = 36 * QDIV + 1;
  localparam int CLAT = 4 * QDIV + 1;
  localparam logic [1:0] OpStart = 2'b00, OpStop = 2'b01, OpWrite = 2'b10, OpRead = 2'b11;

  logic clk = 1'b0, rst = 1'b0;
  logic cmd_valid = 1'b0, cmd_nack = 1'b0;
  logic [1:0] cmd_op = 2'b00;
  logic [7:0] cmd_wdata = 8'h00;
  logic cmd_ready, rsp_valid, rsp_ack, rsp_err, busy, bus_held;
  logic [7:0] rsp_rdata;
  logic io_scl, io_sda_in, io_sda_out, io_sda_ctrl;

  int nvec = 0, nerr = 0;
  int slv_mode = 0;            // 0 idle, 1 ack the 9th bit, 2 send slv_data
  logic [7:0] slv_data = 8'h00;
  int base_fall = 0, base_rise = 0, d_slv;
  int falls = 0, rises = 0, starts = 0, stops = 0;
  logic rise_sda [4096];
  logic rise_ctrl [4096];
  logic slave_low, sda_bus;
  logic [7:0] exp_rdata = 8'h00;

  i2c_master_seq #(.QDIV(QDIV), .QDIV_W(16)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_wdata(cmd_wdata), .cmd_nack(cmd_nack), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_ack(rsp_ack), .rsp_err(rsp_err), .busy(busy), .bus_held(bus_held), .io_scl(io_scl),
    .io_sda_in(io_sda_in), .io_sda_out(io_sda_out), .io_sda_ctrl(io_sda_ctrl)
  );

  always #5 clk = ~clk;

  // Slave bit index = SCL falls since the command was issued.
  always_comb begin
    slave_low = 1'b0;
    d_slv = falls - base_fall;
    if (slv_mode == 1 && d_slv == 8) slave_low = 1'b1;
    else if (slv_mode == 2 && d_slv >= 0 && d_slv < 8) slave_low = ~slv_data[3'(7 - d_slv)];
  end
  assign sda_bus   = ~io_sda_ctrl & ~slave_low;
  assign io_sda_in = sda_bus;

  always @(posedge io_scl) begin
    rise_sda[rises % 4096]  = sda_bus;
    rise_ctrl[rises % 4096] = io_sda_ctrl;
    rises = rises + 1;
  end
  always @(negedge io_scl) falls = falls + 1;
  always @(negedge sda_bus) if (io_scl === 1'b1 && rst) starts = starts + 1;
  always @(posedge sda_bus) if (io_scl === 1'b1 && rst) stops = stops + 1;

  function automatic logic [8:0] bus_bits(input int b);
    logic [8:0] v;
    for (int k = 0; k < 9; k++) v[8-k] = rise_sda[(b + k) % 4096];
    return v;
  endfunction

  task automatic do_cmd(input logic [1:0] op, input logic [7:0] wd, input logic nk,
                        output int lat);
    int w;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_wdata = wd; cmd_nack = nk;
    w = 0;
    while (!cmd_ready && w < 1000) begin @(negedge clk); w++; end
    base_fall = falls; base_rise = rises;
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 1000) begin @(negedge clk); lat++; end
  endtask

  task automatic test_reset();
    int lat;
    repeat (3) @(negedge clk);
    nvec++; if ({io_scl, io_sda_ctrl, io_sda_out, cmd_ready, busy, bus_held} !== 6'b100100) begin
      nerr++; $display("FAIL reset_lines: got %b want 100100",
                       {io_scl, io_sda_ctrl, io_sda_out, cmd_ready, busy, bus_held}); end
    nvec++; if ({rsp_valid, rsp_ack, rsp_err, rsp_rdata} !== 11'h0) begin
      nerr++; $display("FAIL reset_rsp: got %h want 0", {rsp_valid, rsp_ack, rsp_err, rsp_rdata}); end
    rst = 1'b1;
    do_cmd(OpStart, 8'h00, 1'b0, lat);
    @(negedge clk); cmd_valid = 1'b1; cmd_op = OpWrite; cmd_wdata = 8'h5A;
    @(negedge clk); cmd_valid = 1'b0;
    repeat (40) @(negedge clk);
    nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL midbyte_busy: got %b want 1", busy); end
    rst = 1'b0;
    #1;
    nvec++; if ({io_scl, io_sda_ctrl, busy, bus_held, cmd_ready} !== 5'b10001) begin
      nerr++; $display("FAIL reset_abort: got %b want 10001",
                       {io_scl, io_sda_ctrl, busy, bus_held, cmd_ready}); end
    @(negedge clk); rst = 1'b1;
    do_cmd(OpStart, 8'h00, 1'b0, lat);
    nvec++; if (lat !== CLAT || bus_held !== 1'b1 || rsp_err !== 1'b0) begin
      nerr++; $display("FAIL start_after_reset: lat %0d held %b err %b want %0d 1 0",
                       lat, bus_held, rsp_err, CLAT); end
  endtask

  task automatic test_write();
    int lat;
    slv_mode = 1;
    do_cmd(OpWrite, 8'hA5, 1'b0, lat);
    slv_mode = 0;
    nvec++; if (lat !== XLAT) begin nerr++; $display("FAIL write_lat: got %0d want %0d", lat, XLAT); end
    nvec++; if (rises - base_rise !== 9) begin
      nerr++; $display("FAIL write_pulses: got %0d want 9", rises - base_rise); end
    nvec++; if (bus_bits(base_rise) !== {8'hA5, 1'b0}) begin
      nerr++; $display("FAIL write_bits: got %b want %b", bus_bits(base_rise), {8'hA5, 1'b0}); end
    nvec++; if (rsp_ack !== 1'b1 || rsp_err !== 1'b0) begin
      nerr++; $display("FAIL write_ack: got ack %b err %b want 1 0", rsp_ack, rsp_err); end
    nvec++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
      nerr++; $display("FAIL write_done: got busy %b ready %b want 0 1", busy, cmd_ready); end
  endtask

  task automatic test_read();
    int lat;
    slv_mode = 2; slv_data = 8'h3C;
    do_cmd(OpRead, 8'h00, 1'b1, lat);
    slv_mode = 0; exp_rdata = 8'h3C;
    nvec++; if (lat !== XLAT) begin nerr++; $display("FAIL read_lat: got %0d want %0d", lat, XLAT); end
    nvec++; if (rsp_rdata !== 8'h3C) begin
      nerr++; $display("FAIL read_data: got %h want 3c", rsp_rdata); end
    nvec++; if (rise_ctrl[(base_rise + 8) % 4096] !== 1'b0 || bus_bits(base_rise) !== {8'h3C, 1'b1}) begin
      nerr++; $display("FAIL read_bit8: ctrl %b bits %b want 0 %b", rise_ctrl[(base_rise + 8) % 4096],
                       bus_bits(base_rise), {8'h3C, 1'b1}); end
    nvec++; if (rsp_ack !== 1'b0 || rsp_err !== 1'b0) begin
      nerr++; $display("FAIL read_flags: got ack %b err %b want 0 0", rsp_ack, rsp_err); end
  endtask

  task automatic test_random();
    int lat;
    logic rd, flag;
    logic [7:0] d;
    logic [8:0] exp_bits;
    for (int i = 0; i < 16; i++) begin
      rd = 1'($urandom_range(0, 1)); flag = 1'($urandom_range(0, 1)); d = 8'($urandom);
      if (rd) begin
        slv_mode = 2; slv_data = d;
        do_cmd(OpRead, 8'($urandom), flag, lat);
        exp_rdata = d; exp_bits = {d, flag};
      end else begin
        slv_mode = flag ? 1 : 0;
        do_cmd(OpWrite, d, 1'($urandom_range(0, 1)), lat);
        exp_bits = {d, ~flag};
      end
      slv_mode = 0;
      nvec++; if (lat !== XLAT || rises - base_rise !== 9) begin
        nerr++; $display("FAIL rand%0d_timing: lat %0d pulses %0d want %0d 9", i, lat,
                         rises - base_rise, XLAT); end
      nvec++; if (bus_bits(base_rise) !== exp_bits) begin
        nerr++; $display("FAIL rand%0d_bits: got %b want %b", i, bus_bits(base_rise), exp_bits); end
      nvec++; if (rsp_rdata !== exp_rdata || rsp_err !== 1'b0 || rsp_ack !== (!rd && flag)) begin
        nerr++; $display("FAIL rand%0d_rsp: data %h err %b ack %b want %h 0 %b", i, rsp_rdata,
                         rsp_err, rsp_ack, exp_rdata, (!rd && flag)); end
    end
  endtask

  task automatic test_illegal();
    int lat, r0, f0;
    logic [1:0] ops [3];
    ops[0] = OpWrite; ops[1] = OpRead; ops[2] = OpStop;
    do_cmd(OpStop, 8'h00, 1'b0, lat);
    nvec++; if (lat !== CLAT || bus_held !== 1'b0 || io_scl !== 1'b1 || io_sda_ctrl !== 1'b0) begin
      nerr++; $display("FAIL stop_idle: lat %0d held %b scl %b ctrl %b want %0d 0 1 0",
                       lat, bus_held, io_scl, io_sda_ctrl, CLAT); end
    for (int i = 0; i < 3; i++) begin
      r0 = rises; f0 = falls;
      do_cmd(ops[i], 8'($urandom), 1'b0, lat);
      nvec++; if (lat !== 1 || rsp_err !== 1'b1 || rsp_ack !== 1'b0) begin
        nerr++; $display("FAIL illegal%0d_rsp: lat %0d err %b ack %b want 1 1 0", i, lat,
                         rsp_err, rsp_ack); end
      repeat (3) @(negedge clk);
      nvec++; if (io_scl !== 1'b1 || rises != r0 || falls != f0 || bus_held !== 1'b0 ||
                  cmd_ready !== 1'b1 || rsp_rdata !== exp_rdata) begin
        nerr++; $display("FAIL illegal%0d_bus: scl %b edges %0d held %b ready %b data %h want 1 0 0 1 %h",
                         i, io_scl, rises - r0 + falls - f0, bus_held, cmd_ready, rsp_rdata, exp_rdata); end
    end
  endtask

  task automatic test_restart();
    int lat, s0, p0, bad;
    logic [1:0] ops [3];
    ops[0] = OpStart; ops[1] = OpStart; ops[2] = OpStop;
    s0 = starts; p0 = stops; bad = 0;
    for (int i = 0; i < 3; i++) begin
      do_cmd(ops[i], 8'h00, 1'b0, lat);
      if (lat != CLAT || rsp_err !== 1'b0) bad++;
    end
    nvec++; if (bad != 0) begin nerr++; $display("FAIL restart_lat: got %0d bad responses want 0", bad); end
    nvec++; if (starts - s0 !== 2 || stops - p0 !== 1) begin
      nerr++; $display("FAIL restart_conds: got %0d starts %0d stops want 2 1", starts - s0, stops - p0); end
    nvec++; if (bus_held !== 1'b0 || io_scl !== 1'b1 || io_sda_ctrl !== 1'b0) begin
      nerr++; $display("FAIL restart_final: held %b scl %b ctrl %b want 0 1 0", bus_held, io_scl,
                       io_sda_ctrl); end
  endtask

  task automatic test_back_to_back();
    int lat, cyc, early, w;
    do_cmd(OpStart, 8'h00, 1'b0, lat);
    slv_mode = 1;
    @(negedge clk); cmd_valid = 1'b1; cmd_op = OpWrite; cmd_wdata = 8'($urandom);
    w = 0;
    while (!cmd_ready && w < 1000) begin @(negedge clk); w++; end
    base_fall = falls; base_rise = rises;
    @(negedge clk);
    cmd_op = OpStop;
    cyc = 1; early = 0;
    while (!rsp_valid && cyc < 1000) begin
      if (cmd_ready) early++;
      @(negedge clk); cyc++;
    end
    nvec++; if (cyc !== XLAT || early !== 0) begin
      nerr++; $display("FAIL b2b_hold: lat %0d early ready %0d want %0d 0", cyc, early, XLAT); end
    nvec++; if (cmd_ready !== 1'b1 || busy !== 1'b0 || rsp_ack !== 1'b1) begin
      nerr++; $display("FAIL b2b_rsp: ready %b busy %b ack %b want 1 0 1", cmd_ready, busy, rsp_ack); end
    @(negedge clk);
    cmd_valid = 1'b0;
    nvec++; if (busy !== 1'b1 || bus_held !== 1'b1) begin
      nerr++; $display("FAIL b2b_accept: busy %b held %b want 1 1", busy, bus_held); end
    lat = 1;
    while (!rsp_valid && lat < 1000) begin @(negedge clk); lat++; end
    slv_mode = 0;
    nvec++; if (lat !== CLAT || bus_held !== 1'b0) begin
      nerr++; $display("FAIL b2b_stop: lat %0d held %b want %0d 0", lat, bus_held, CLAT); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_random();
    test_illegal();
    test_restart();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
